// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding is fixed so that bit 0 marks the two filtering states.
package button_debouncer_pkg;

  localparam int DB_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } db_state_e;

endpackage : button_debouncer_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, then a stable-time filter FSM.
// The input is already polarity-normalised (1 = pressed).
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_in,
  output logic level_o,
  output logic busy_o
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sync_d  = {sync_q[0], p_in};
    s       = sync_q[1];
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    busy_d  = busy_q;

    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A reversal aborts the window; the count restarts from zero next time.
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// Multi-channel key conditioner: polarity normalisation plus one independent
// debounce_channel per key, producing a clean registered "pressed" level.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_busy
);

  logic [N_BTN-1:0] btn_p;

  assign btn_p = btn_raw ^ {N_BTN{ACTIVE_LOW_IN}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .p_in   (btn_p[i]),
      .level_o(btn_level[i]),
      .busy_o (btn_busy[i])
    );
  end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (N_BTN=2, DB_CYCLES=4, active-low keys).
// Expectations are queued with the cycle they are due and checked at the falling edge.
module tb_button_debouncer;

  localparam int N  = 2;
  localparam int DB = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_busy;

  button_debouncer #(
    .N_BTN        (N),
    .DB_CYCLES    (DB),
    .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_busy (btn_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] lvl;
    logic [N-1:0] bsy;
    bit           chk_bsy;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic push(input int c, input logic [N-1:0] l, input logic [N-1:0] b,
                      input bit cb, input string tag);
    exp_t e;
    e.cyc     = c;
    e.lvl     = l;
    e.bsy     = b;
    e.chk_bsy = cb;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // One rising edge, then compare everything due on that edge at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check({sb[i].tag, "_level"}, btn_level, sb[i].lvl);
        if (sb[i].chk_bsy) check({sb[i].tag, "_busy"}, btn_busy, sb[i].bsy);
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t;
    rst_n   = 1'b0;
    btn_raw = 2'b10;
    ticks(3);
    check("reset_level", btn_level, 2'b00);
    check("reset_busy", btn_busy, 2'b00);

    // Clean press: key 0 already held as reset releases.
    rst_n = 1'b1;
    t = cyc;
    push(t + 2, 2'b00, 2'b00, 1, "press_e2");
    for (int k = 3; k <= 6; k++) push(t + k, 2'b00, 2'b01, 1, "press_wait");
    push(t + 7, 2'b01, 2'b00, 1, "press_e7");
    ticks(8);

    // High glitch of 3 cycles while pressed.
    t = cyc;
    btn_raw = 2'b11;
    for (int k = 1; k <= 10; k++)
      push(t + k, 2'b01, (k >= 3 && k <= 5) ? 2'b01 : 2'b00, 1, "hi_glitch");
    ticks(3);
    btn_raw = 2'b10;
    ticks(7);

    // Release.
    t = cyc;
    btn_raw = 2'b11;
    for (int k = 1; k <= 6; k++)
      push(t + k, 2'b01, (k >= 3) ? 2'b01 : 2'b00, 1, "release_wait");
    push(t + 7, 2'b00, 2'b00, 1, "release_e7");
    ticks(8);

    // Low glitch of 3 cycles while released.
    t = cyc;
    btn_raw = 2'b10;
    for (int k = 1; k <= 12; k++)
      push(t + k, 2'b00, (k >= 3 && k <= 5) ? 2'b01 : 2'b00, 1, "lo_glitch");
    ticks(3);
    btn_raw = 2'b11;
    ticks(9);

    // Bounce: toggle every 2 cycles for 12 cycles, then hold pressed.
    t = cyc;
    for (int k = 1; k <= 18; k++) push(t + k, 2'b00, 2'b00, 0, "bounce_hold");
    push(t + 18, 2'b00, 2'b01, 1, "bounce_pre");
    push(t + 19, 2'b01, 2'b00, 1, "bounce_e19");
    for (int seg = 0; seg < 6; seg++) begin
      btn_raw[0] = seg[0];
      ticks(2);
    end
    btn_raw[0] = 1'b0;
    ticks(8);

    // Return key 0 to released.
    t = cyc;
    btn_raw = 2'b11;
    push(t + 6, 2'b01, 2'b01, 1, "rel2_pre");
    push(t + 7, 2'b00, 2'b00, 1, "rel2_e7");
    ticks(8);

    // Independence: key 1 pressed two cycles after key 0.
    t = cyc;
    btn_raw = 2'b10;
    push(t + 2,  2'b00, 2'b00, 1, "indep_2");
    push(t + 3,  2'b00, 2'b01, 1, "indep_3");
    push(t + 4,  2'b00, 2'b01, 1, "indep_4");
    push(t + 5,  2'b00, 2'b11, 1, "indep_5");
    push(t + 6,  2'b00, 2'b11, 1, "indep_6");
    push(t + 7,  2'b01, 2'b10, 1, "indep_7");
    push(t + 8,  2'b01, 2'b10, 1, "indep_8");
    push(t + 9,  2'b11, 2'b00, 1, "indep_9");
    push(t + 10, 2'b11, 2'b00, 1, "indep_10");
    ticks(2);
    btn_raw = 2'b00;
    ticks(8);

    // Release both together.
    t = cyc;
    btn_raw = 2'b11;
    push(t + 6, 2'b11, 2'b11, 1, "relboth_6");
    push(t + 7, 2'b00, 2'b00, 1, "relboth_7");
    ticks(8);

    // Reset mid-filter: key 0 in PRESS_WAIT with cnt=2 when reset hits.
    t = cyc;
    btn_raw = 2'b10;
    push(t + 3, 2'b00, 2'b01, 1, "midrst_3");
    push(t + 5, 2'b00, 2'b01, 1, "midrst_5");
    ticks(5);
    rst_n = 1'b0;
    #1;
    check("midrst_level", btn_level, 2'b00);
    check("midrst_busy", btn_busy, 2'b00);
    ticks(2);
    check("midrst_hold_busy", btn_busy, 2'b00);
    rst_n = 1'b1;
    t = cyc;
    push(t + 2, 2'b00, 2'b00, 1, "after_rst_2");
    push(t + 3, 2'b00, 2'b01, 1, "after_rst_3");
    push(t + 6, 2'b00, 2'b01, 1, "after_rst_6");
    push(t + 7, 2'b01, 2'b00, 1, "after_rst_7");
    ticks(8);

    total++;
    assert (sb.size() === 0) else begin
      bad++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_debouncer
